eq_run_detector: RTL

- Sequential consumer of an equality comparison between two W-bit symbol streams.
- Per accepted sample pair (a, b): evaluates a == b and tracks the current run of consecutive equal samples.
- Asserts locked once the run reaches RUN_LEN. On the mismatch that ends a locked run, emits a one-entry run-length event over a valid/ready handshake.
- Sits directly downstream of the 2-bit equality comparator stage; the default W=2 matches it.

---
 rtl/eq_run_detector_if.sv | 35 +++
 rtl/eq_run_detector.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/eq_run_detector_if.sv
// eq_run_detector_if
// Purpose: groups the sample-input handshake and the run-length event handshake
//          of eq_run_detector into one bundle.
// Signals:
//   in_valid  - a/b sample present (upstream -> detector)
//   a, b      - W-bit symbols to compare (upstream -> detector)
//   in_ready  - detector accepts a sample this cycle (detector -> upstream)
//   evt_valid - run-length event pending (detector -> downstream)
//   evt_len   - length of the finished locked run, saturated (detector -> downstream)
//   evt_ready - downstream accepts the event (downstream -> detector)
// Modports:
//   master - the environment driving samples and consuming events
//   slave  - the detector itself
interface eq_run_detector_if #(
  parameter int W     = 2,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             in_ready;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_len;
  logic             evt_ready;

  modport master (
    output in_valid, a, b, evt_ready,
    input  in_ready, evt_valid, evt_len
  );

  modport slave (
    input  in_valid, a, b, evt_ready,
    output in_ready, evt_valid, evt_len
  );
endinterface

// File: rtl/eq_run_detector.sv
// eq_run_detector
// Purpose: consumes (a, b) sample pairs, tracks the current run of consecutive
//          equal samples, raises locked once the run reaches RUN_LEN and, on the
//          mismatch that ends a locked run, offers the run length as a single
//          event over a valid/ready handshake.
// Parameters:
//   W       - symbol width of a and b
//   RUN_LEN - consecutive equal samples needed to lock (1 .. 2^CNT_W-1)
//   CNT_W   - width of the run counter, evt_len, match_total (and mismatch_cnt)
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high reset
//   bus          - eq_run_detector_if.slave (in_valid/a/b/in_ready, evt_valid/evt_len/evt_ready)
//   locked       - current run >= RUN_LEN (registered)
//   match_total  - total accepted equal samples, wraps modulo 2^CNT_W
//   mismatch_cnt - accepted unequal samples, saturating; present only when
//                  EQ_RUN_DETECTOR_MISMATCH_CNT_EN is defined
// Optional feature macro: EQ_RUN_DETECTOR_MISMATCH_CNT_EN
module eq_run_detector #(
  parameter int W       = 2,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  eq_run_detector_if.slave   bus,
  output logic               locked,
`ifdef EQ_RUN_DETECTOR_MISMATCH_CNT_EN
  output logic [CNT_W-1:0]   mismatch_cnt,
`endif
  output logic [CNT_W-1:0]   match_total
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(RUN_LEN);

  state_t           state_reg;
  logic [CNT_W-1:0] run_reg;
  logic             locked_reg;
  logic             in_ready_reg;
  logic             evt_valid_reg;
  logic [CNT_W-1:0] evt_len_reg;
  logic [CNT_W-1:0] match_total_reg;

  logic             accept;
  logic             eq;
  logic [CNT_W-1:0] run_inc;

  // in_ready is registered and is low only in REPORT, so a sample offered
  // while an event is pending simply waits upstream.
  assign accept  = bus.in_valid && in_ready_reg;
  assign eq      = (bus.a == bus.b);
  // Saturating successor of the run counter; reused for the lock test so that
  // the lock condition looks at the value the counter is about to take.
  assign run_inc = (run_reg == CNT_MAX) ? run_reg : run_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= SEARCH;
      run_reg         <= '0;
      locked_reg      <= 1'b0;
      in_ready_reg    <= 1'b1;
      evt_valid_reg   <= 1'b0;
      evt_len_reg     <= '0;
      match_total_reg <= '0;
    end else begin
      // Run and total counters follow every accepted sample regardless of state.
      if (accept) begin
        if (eq) begin
          run_reg         <= run_inc;
          match_total_reg <= match_total_reg + 1'b1;
        end else begin
          run_reg <= '0;
        end
      end

      case (state_reg)
        SEARCH: begin
          // Runs shorter than RUN_LEN end silently: run is cleared above.
          if (accept && eq && (run_inc == RUN_TARGET)) begin
            state_reg  <= LOCKED;
            locked_reg <= 1'b1;
          end
        end

        LOCKED: begin
          if (accept && !eq) begin
            // Capture the run length before the clear above takes effect.
            state_reg     <= REPORT;
            evt_len_reg   <= run_reg;
            evt_valid_reg <= 1'b1;
            locked_reg    <= 1'b0;
            in_ready_reg  <= 1'b0;
          end
        end

        REPORT: begin
          // No samples are accepted here, so run stays at 0 until we leave.
          if (bus.evt_ready) begin
            state_reg     <= SEARCH;
            evt_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg     <= SEARCH;
          run_reg       <= '0;
          locked_reg    <= 1'b0;
          in_ready_reg  <= 1'b1;
          evt_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef EQ_RUN_DETECTOR_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mismatch_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_cnt_reg <= '0;
    end else if (accept && !eq && (mismatch_cnt_reg != CNT_MAX)) begin
      mismatch_cnt_reg <= mismatch_cnt_reg + 1'b1;
    end
  end

  assign mismatch_cnt = mismatch_cnt_reg;
`endif

  assign bus.in_ready  = in_ready_reg;
  assign bus.evt_valid = evt_valid_reg;
  assign bus.evt_len   = evt_len_reg;
  assign locked        = locked_reg;
  assign match_total   = match_total_reg;

endmodule
